aes_job_arbiter: RTL and testbench
==================================

Name: aes_job_arbiter

Overview:
Shares one AES-128 encryption core between NREQ requesters. The block holds a round-robin grant, latches the winning requester's key and plaintext, and sequences the core through a start/done handshake. It returns the ciphertext to the requester tagged with its ID, and an error flag if the core stalls. It sits between the host-side job sources and the cipher core, in place of the bench-driven key/plaintext loading.

Parameters:
NREQ, 2, number of requesters (2..8); IDW = clog2(NREQ), min 1
TIMEOUT_CYC, 64, maximum cycles in WAIT before the job is aborted (>=2)

Ports:
clk  in  1  system clock, all logic on posedge
rst_  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester job valid
req_ready  out  NREQ  one-hot accept pulse; a job transfers when req_valid[i] && req_ready[i]
req_key  in  NREQ*128  flattened keys, requester i at [128*i+:128]
req_pt  in  NREQ*128  flattened plaintexts, same packing
core_start  out  1  single-cycle launch pulse to the core
core_key  out  128  key to the core, stable from core_start until core_done or core_abort
core_pt  out  128  plaintext to the core, same stability rule
core_done  in  1  single-cycle completion pulse from the core
core_ct  in  128  ciphertext, valid when core_done=1
core_abort  out  1  single-cycle pulse on timeout; the core returns to idle
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  IDW  requester index of the response
rsp_data  out  128  ciphertext, or 0 on error
rsp_err  out  1  1 = job timed out

Behaviour:
- Reset (rst_=0, asynchronous): state=IDLE, rr_ptr=0, wait counter=0. All outputs are 0: req_ready, core_start, core_abort, rsp_valid, rsp_err, rsp_id, rsp_data, core_key, core_pt.
- Reset mid-job: the job is dropped silently. No response is issued and no core_abort is driven; the core is reset by the same rst_.
- Four states: IDLE, ISSUE, WAIT, RESP.
- IDLE, when any req_valid is high:
  - Pick the first set bit searching upward from rr_ptr, wrapping modulo NREQ.
  - Assert req_ready for that bit combinationally in the same cycle.
  - On the clock edge, latch key, pt and id, and go to ISSUE.
  - req_ready is 0 in every other state.
- ISSUE: core_start=1 for exactly one cycle. Clear the wait counter. Go to WAIT.
- WAIT:
  - The counter increments each cycle.
  - core_done=1: latch core_ct into rsp_data, set rsp_err=0, go to RESP.
  - Counter reaches TIMEOUT_CYC-1 with core_done=0: pulse core_abort for that cycle, set rsp_data=0 and rsp_err=1, go to RESP.
  - If core_done and the timeout condition occur in the same cycle, done wins and no abort is issued.
  - core_done in any state other than WAIT is ignored.
- RESP:
  - rsp_valid=1, with rsp_id, rsp_data and rsp_err held stable until rsp_ready.
  - On the rsp_valid && rsp_ready edge: rsp_valid goes to 0, rr_ptr = (granted id + 1) mod NREQ, state goes to IDLE.
  - A new grant is possible on the next cycle at the earliest; there is no same-cycle RESP-to-grant bypass.
- Latency, fixed in cycles:
  - Accept at cycle T; core_start at T+1.
  - core_done at T+1+L; rsp_valid at T+2+L.
  - Minimum job interval is L+4 cycles when rsp_ready is held at 1.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0. No requester waits more than NREQ-1 jobs.
- rr_ptr is updated only on a completed response, including error responses.
- core_key and core_pt:
  - Register outputs updated only at accept.
  - They hold their value through RESP and IDLE until the next accept.

Test Plan:
- Single job on requester 0: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, core model latency L=11 -> core_start 1 cycle after accept, rsp_valid 13 cycles after accept, rsp_id=0, rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a, rsp_err=0.
- Both requesters valid continuously for 6 jobs, rsp_ready=1 -> grant order 0,1,0,1,0,1. Each rsp_id matches its own key/pt result. Job interval is 15 cycles.
- Backpressure: rsp_ready held at 0 for 20 cycles -> rsp_valid, rsp_id and rsp_data stay stable, req_ready stays 0 throughout, and no core_start is issued.
- Timeout: core never returns done, TIMEOUT_CYC=64 -> core_abort pulses once 64 cycles after core_start, rsp_err=1, rsp_data=0. The next job is then accepted and completes normally.
- core_done in the same cycle the counter reaches TIMEOUT_CYC-1 -> rsp_err=0, correct ciphertext, core_abort stays 0.
- rst_ asserted in WAIT asynchronously between edges -> all outputs go to 0 immediately and no response appears. After release, requester 0 wins first (rr_ptr=0).

Source files
------------

// File: rtl/aes_job_arbiter.sv
// Round-robin job arbiter sharing one AES-128 core between NREQ requesters.
// Sequences the core through start/done, times out stalled jobs, returns tagged results.
module aes_job_arbiter #(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = 64,
    localparam int IDW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*128-1:0] req_key,
    input  logic [NREQ*128-1:0] req_pt,
    output logic                core_start,
    output logic [127:0]        core_key,
    output logic [127:0]        core_pt,
    input  logic                core_done,
    input  logic [127:0]        core_ct,
    output logic                core_abort,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [127:0]        rsp_data,
    output logic                rsp_err
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_ptr;
    logic [CW-1:0]   wait_cnt;
    logic            gap_q;
    logic [NREQ-1:0] rot_valid;
    logic            grant_vld;
    logic [IDW:0]    grant_off;
    logic [IDW:0]    grant_sum;
    logic [IDW-1:0]  grant_id;
    logic            can_grant;
    logic            timeout_hit;
    logic            rsp_fire;
    logic [127:0]    sel_key;
    logic [127:0]    sel_pt;

    // Rotate so bit 0 is the requester at rr_ptr; the lowest set bit wins.
    assign rot_valid = NREQ'({req_valid, req_valid} >> rr_ptr);

    always_comb begin
        grant_vld = 1'b0;
        grant_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                grant_vld = 1'b1;
                grant_off = (IDW+1)'(k);
            end
        end
        grant_sum = {1'b0, rr_ptr} + grant_off;
        if (grant_sum >= (IDW+1)'(NREQ))
            grant_sum = grant_sum - (IDW+1)'(NREQ);
    end

    assign grant_id = grant_sum[IDW-1:0];

    always_comb begin
        sel_key = '0;
        sel_pt  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                sel_key = req_key[i*128 +: 128];
                sel_pt  = req_pt[i*128 +: 128];
            end
        end
    end

    // gap_q blocks the grant for one cycle after each response and while in reset,
    // giving the L+4 job spacing and keeping req_ready low during reset.
    assign can_grant   = (state_q == S_IDLE) && !gap_q && grant_vld;
    assign timeout_hit = (state_q == S_WAIT) && (wait_cnt == CW'(TIMEOUT_CYC - 1)) && !core_done;
    assign rsp_fire    = (state_q == S_RESP) && rsp_ready;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (can_grant) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (core_done || timeout_hit) state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = can_grant ? (NREQ'(1) << grant_id) : '0;
        core_start = (state_q == S_ISSUE);
        core_abort = timeout_hit;
        rsp_valid  = (state_q == S_RESP);
    end

    // Control: wait counter, round-robin pointer, post-response turnaround.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wait_cnt <= '0;
            rr_ptr   <= '0;
            gap_q    <= 1'b1;
        end else begin
            if (state_q == S_ISSUE)
                wait_cnt <= '0;
            else if (state_q == S_WAIT)
                wait_cnt <= wait_cnt + CW'(1);
            if (rsp_fire)
                rr_ptr <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + IDW'(1);
            gap_q <= rsp_fire;
        end
    end

    // Data: job capture at accept, result capture on done or timeout.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            core_key <= '0;
            core_pt  <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (can_grant) begin
                core_key <= sel_key;
                core_pt  <= sel_pt;
                rsp_id   <= grant_id;
            end
            if (state_q == S_WAIT && core_done) begin
                rsp_data <= core_ct;
                rsp_err  <= 1'b0;
            end else if (timeout_hit) begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_job_arbiter.sv
// Bench for aes_job_arbiter: stand-in AES core, timestamp-based job model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_aes_job_arbiter;

    localparam int NREQ = 2;
    localparam int TO   = 64;
    localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1     = 128'h3243f6a8885a308d313198a2e0370734;

    logic                clk = 1'b0;
    logic                rst_ = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*128-1:0] req_key = '0;
    logic [NREQ*128-1:0] req_pt = '0;
    logic                core_start;
    logic [127:0]        core_key;
    logic [127:0]        core_pt;
    logic                core_done;
    logic [127:0]        core_ct;
    logic                core_abort;
    logic                rsp_valid;
    logic                rsp_ready = 1'b1;
    logic [0:0]          rsp_id;
    logic [127:0]        rsp_data;
    logic                rsp_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int core_lat = 11;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_job_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_(rst_),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .req_pt(req_pt),
        .core_start(core_start), .core_key(core_key), .core_pt(core_pt),
        .core_done(core_done), .core_ct(core_ct), .core_abort(core_abort),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    // Stand-in cipher: the FIPS-197 vector is exact, anything else is a fixed mix.
    function automatic logic [127:0] fake_aes(input logic [127:0] k, input logic [127:0] p);
        if (k == FIPS_K && p == FIPS_P) return FIPS_C;
        return k ^ {p[63:0], p[127:64]} ^ 128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Core model: done arrives core_lat cycles after start; core_lat=0 means it hangs.
    logic         cm_busy;
    int           cm_done_at;
    logic [127:0] cm_key, cm_pt;
    always @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cm_busy   <= 1'b0;
            core_done <= 1'b0;
            core_ct   <= '0;
        end else begin
            core_done <= 1'b0;
            core_ct   <= '0;
            if (core_start) begin
                cm_busy    <= 1'b1;
                cm_done_at <= (core_lat > 0) ? cyc + core_lat : -1;
                cm_key     <= core_key;
                cm_pt      <= core_pt;
            end else if (core_abort) begin
                cm_busy <= 1'b0;
            end else if (cm_busy && cm_done_at == cyc + 1) begin
                core_done <= 1'b1;
                core_ct   <= fake_aes(cm_key, cm_pt);
                cm_busy   <= 1'b0;
            end
        end
    end

    // Job model state (timestamps, not FSM states) and observation log.
    bit           m_busy = 0;
    int           m_rr = 0, m_next_free = 2, m_acc = 0, m_id = 0, m_resp_from = -1;
    logic [127:0] m_key = '0, m_pt = '0, m_rdata = '0;
    logic         m_rerr = 1'b0;
    int           n_acc = 0, n_rv = 0, n_abort = 0, n_start = 0;
    int           last_acc = 0, last_start = 0, last_abort = 0, last_rv = 0;
    int           acc_ids[$];
    int           acc_cycs[$];
    int           rv_id = 0;
    logic [127:0] rv_data = '0;
    logic         rv_err = 1'b0;
    bit           prev_rv = 0;

    always @(negedge clk) begin : model_cmp
        logic [NREQ-1:0] exp_ready;
        logic exp_start, exp_abort, exp_valid;
        bit   found;
        int   pick;
        if (!rst_) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_core_start", core_start, 0);
            chk("rst_core_abort", core_abort, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_core_key", core_key, 0);
            chk("rst_core_pt", core_pt, 0);
            m_busy = 0; m_rr = 0; m_key = '0; m_pt = '0;
            m_next_free = cyc + 2; prev_rv = 0;
        end else begin
            exp_ready = '0;
            found = 0;
            pick = 0;
            if (!m_busy && cyc >= m_next_free) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (!found && req_valid[(m_rr + k) % NREQ]) begin
                        found = 1;
                        pick = (m_rr + k) % NREQ;
                    end
                end
                if (found) exp_ready[pick] = 1'b1;
            end
            exp_start = m_busy && (cyc == m_acc + 1);
            exp_abort = m_busy && (m_resp_from < 0) && (cyc == m_acc + 1 + TO) && !core_done;
            exp_valid = m_busy && (m_resp_from >= 0) && (cyc >= m_resp_from);

            chk("req_ready", req_ready, exp_ready);
            chk("core_start", core_start, exp_start);
            chk("core_abort", core_abort, exp_abort);
            chk("rsp_valid", rsp_valid, exp_valid);
            chk("core_key", core_key, m_key);
            chk("core_pt", core_pt, m_pt);
            if (exp_valid) begin
                chk("rsp_id", rsp_id, 128'(m_id));
                chk("rsp_data", rsp_data, m_rdata);
                chk("rsp_err", rsp_err, m_rerr);
            end

            for (int k = 0; k < NREQ; k++) begin
                if (req_valid[k] && req_ready[k]) begin
                    n_acc++; last_acc = cyc;
                    acc_ids.push_back(k); acc_cycs.push_back(cyc);
                end
            end
            if (core_start) begin n_start++; last_start = cyc; end
            if (core_abort) begin n_abort++; last_abort = cyc; end
            if (rsp_valid && !prev_rv) begin
                n_rv++; last_rv = cyc;
                rv_id = int'(rsp_id); rv_data = rsp_data; rv_err = rsp_err;
            end
            prev_rv = rsp_valid;

            if (m_busy && m_resp_from < 0 && cyc >= m_acc + 2 && core_done) begin
                m_resp_from = cyc + 1; m_rdata = fake_aes(m_key, m_pt); m_rerr = 1'b0;
            end else if (exp_abort) begin
                m_resp_from = cyc + 1; m_rdata = '0; m_rerr = 1'b1;
            end
            if (exp_valid && rsp_ready) begin
                m_busy = 0; m_rr = (m_id + 1) % NREQ; m_next_free = cyc + 2;
            end
            if (found) begin
                m_busy = 1; m_acc = cyc; m_id = pick; m_resp_from = -1;
                m_key = req_key[pick*128 +: 128]; m_pt = req_pt[pick*128 +: 128];
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_ev(input int which, input int target, input int bound, input string nm);
        int n;
        n = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk); #1;
            n = (which == 0) ? n_acc : (which == 1) ? n_rv : n_abort;
            if (n >= target) return;
        end
        checks++; errors++;
        $display("FAIL %s: timeout after %0d cycles, count %0d wanted %0d", nm, bound, n, target);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base, nst, nac;
        logic [127:0] held;
        req_key = {K1, FIPS_K};
        req_pt  = {P1, FIPS_P};
        repeat (3) tick();
        rst_ = 1'b1;

        // Single job on requester 0.
        req_valid = 2'b01;
        wait_ev(0, 1, 10, "t1_accept");
        tick(); req_valid = 2'b00;
        wait_ev(1, 1, 30, "t1_rsp");
        chk("t1_start_lat", 128'(last_start - last_acc), 128'd1);
        chk("t1_rsp_lat", 128'(last_rv - last_acc), 128'd13);
        chk("t1_rsp_id", 128'(rv_id), 128'd0);
        chk("t1_rsp_data", rv_data, FIPS_C);
        chk("t1_rsp_err", 128'(rv_err), 128'd0);

        // Backpressure: requester 1 wins (pointer moved past 0), response held 20 cycles.
        tick(); rsp_ready = 1'b0; req_valid = 2'b11;
        wait_ev(1, 2, 40, "bp_rsp");
        chk("bp_grant_id", 128'(acc_ids[acc_ids.size()-1]), 128'd1);
        nst = n_start; nac = n_acc; held = rv_data;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            chk("bp_rsp_valid", 128'(rsp_valid), 128'd1);
            chk("bp_rsp_id", 128'(rsp_id), 128'd1);
            chk("bp_rsp_data", rsp_data, held);
            chk("bp_req_ready", 128'(req_ready), 128'd0);
        end
        chk("bp_no_start", 128'(n_start), 128'(nst));
        chk("bp_no_accept", 128'(n_acc), 128'(nac));

        // Fairness: both valid, rsp_ready=1, six jobs.
        base = acc_ids.size();
        tick(); rsp_ready = 1'b1;
        wait_ev(0, nac + 6, 200, "rr_accepts");
        tick(); req_valid = 2'b00;
        for (int k = 0; k < 6 && base + k < acc_ids.size(); k++) begin
            chk("rr_order", 128'(acc_ids[base+k]), 128'(k % 2));
            if (k > 0) chk("rr_interval", 128'(acc_cycs[base+k] - acc_cycs[base+k-1]), 128'd15);
        end
        wait_ev(1, 8, 40, "rr_last_rsp");
        chk("rr_last_id", 128'(rv_id), 128'd1);

        // Timeout: core hangs, then the next job completes normally.
        tick(); core_lat = 0; req_valid = 2'b01;
        wait_ev(2, 1, 120, "to_abort");
        core_lat = 11;
        chk("to_abort_delay", 128'(last_abort - last_start), 128'd64);
        wait_ev(1, 9, 10, "to_rsp");
        chk("to_rsp_err", 128'(rv_err), 128'd1);
        chk("to_rsp_data", rv_data, 128'd0);
        wait_ev(0, nac + 8, 20, "to_next_accept");
        tick(); req_valid = 2'b00;
        wait_ev(1, 10, 30, "to_next_rsp");
        chk("to_next_err", 128'(rv_err), 128'd0);
        chk("to_next_data", rv_data, FIPS_C);
        chk("to_abort_once", 128'(n_abort), 128'd1);

        // Done coincides with the last wait cycle: done wins.
        tick(); core_lat = 64; req_valid = 2'b01;
        wait_ev(0, nac + 9, 20, "tie_accept");
        tick(); req_valid = 2'b00;
        wait_ev(1, 11, 100, "tie_rsp");
        chk("tie_err", 128'(rv_err), 128'd0);
        chk("tie_data", rv_data, FIPS_C);
        chk("tie_no_abort", 128'(n_abort), 128'd1);
        chk("tie_rsp_lat", 128'(last_rv - last_start), 128'd65);

        // Asynchronous reset in WAIT, then requester 0 wins despite pointer at 1.
        tick(); core_lat = 11; req_valid = 2'b01;
        wait_ev(0, nac + 10, 20, "rst_accept");
        repeat (4) @(posedge clk);
        #3 rst_ = 1'b0;
        #1;
        chk("arst_core_key", core_key, 128'd0);
        chk("arst_core_pt", core_pt, 128'd0);
        chk("arst_rsp_valid", 128'(rsp_valid), 128'd0);
        chk("arst_req_ready", 128'(req_ready), 128'd0);
        chk("arst_core_start", 128'(core_start), 128'd0);
        req_valid = 2'b11;
        repeat (2) @(posedge clk);
        #1 rst_ = 1'b1;
        wait_ev(0, nac + 11, 10, "post_rst_accept");
        chk("post_rst_grant", 128'(acc_ids[acc_ids.size()-1]), 128'd0);
        chk("post_rst_no_rsp", 128'(n_rv), 128'd11);
        tick(); req_valid = 2'b00;
        wait_ev(1, 12, 30, "post_rst_rsp");
        chk("post_rst_id", 128'(rv_id), 128'd0);
        chk("post_rst_data", rv_data, FIPS_C);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
